// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder
// Consumes the UART receiver's byte stream and parses framed write commands:
//   SYNC, ADDR, LEN, PAYLOAD[LEN], CHK
// The payload is buffered while the 8-bit additive checksum (ADDR + LEN +
// payload, wrapping mod 256) is accumulated. A frame whose checksum matches
// is replayed as consecutive register writes starting at ADDR over a
// valid/ready bus. Oversized, corrupt or stalled frames are dropped and
// reported with a one-cycle flag pulse.
module uart_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic       busy,
  output logic       frame_ok,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_timeout,
  output logic       overrun
);

  // Timer must be able to hold TIMEOUT; buffer index wide enough for MAX_LEN.
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [7:0]    r_base;
  logic [7:0]    r_len;
  logic [7:0]    r_idx;
  logic [7:0]    r_sum;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_buf [MAX_LEN];

  logic r_busy;
  logic r_frameOk;
  logic r_errChk;
  logic r_errLen;
  logic r_errTimeout;
  logic r_overrun;

  logic          w_timerRun;
  logic          w_expire;
  logic          w_lastIdx;
  logic [IW-1:0] w_bufIdx;

  logic w_setOk;
  logic w_setErrChk;
  logic w_setErrLen;
  logic w_setErrTimeout;
  logic w_setOverrun;
  logic w_bufWe;
  logic w_clrIdx;
  logic w_incIdx;

  // The inter-byte timer only runs while a frame is being received; DRAIN is
  // excluded so that a stalled sink can hold the bus indefinitely.
  assign w_timerRun = (r_state == S_ADDR) || (r_state == S_LEN) ||
                      (r_state == S_PAYLOAD) || (r_state == S_CHK);

  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign w_expire  = w_timerRun && !rx_valid && (r_timer == TW'(TIMEOUT - 1));
  assign w_lastIdx = (r_idx == (r_len - 8'd1));
  assign w_bufIdx  = r_idx[IW-1:0];

  // Next-state decode plus the one-shot control strobes for the datapath.
  always_comb begin
    w_nextState     = r_state;
    w_setOk         = 1'b0;
    w_setErrChk     = 1'b0;
    w_setErrLen     = 1'b0;
    w_setErrTimeout = 1'b0;
    w_setOverrun    = 1'b0;
    w_bufWe         = 1'b0;
    w_clrIdx        = 1'b0;
    w_incIdx        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          w_nextState = S_ADDR;
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          w_nextState = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          if (rx_data > 8'(MAX_LEN)) begin
            w_nextState = S_IDLE;
            w_setErrLen = 1'b1;
          end else if (rx_data == 8'd0) begin
            w_nextState = S_CHK;
          end else begin
            w_nextState = S_PAYLOAD;
            w_clrIdx    = 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_valid) begin
          w_bufWe  = 1'b1;
          w_incIdx = 1'b1;
          if (w_lastIdx) begin
            w_nextState = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (rx_valid) begin
          if (rx_data != r_sum) begin
            w_nextState = S_IDLE;
            w_setErrChk = 1'b1;
          end else if (r_len == 8'd0) begin
            w_nextState = S_IDLE;
            w_setOk     = 1'b1;
          end else begin
            w_nextState = S_DRAIN;
            w_clrIdx    = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // Bytes arriving while writes are replayed cannot be buffered; this
        // includes SYNC_BYTE, so there is no resynchronisation here.
        if (rx_valid) begin
          w_setOverrun = 1'b1;
        end
        if (wr_ready) begin
          w_incIdx = 1'b1;
          if (w_lastIdx) begin
            w_nextState = S_IDLE;
            w_setOk     = 1'b1;
          end
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase

    if (w_expire) begin
      w_nextState     = S_IDLE;
      w_setErrTimeout = 1'b1;
    end
  end

  // State register; reset aborts any frame or drain in progress at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Frame datapath: base address, length, running checksum, index and timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base  <= 8'd0;
      r_len   <= 8'd0;
      r_idx   <= 8'd0;
      r_sum   <= 8'd0;
      r_timer <= '0;
    end else begin
      if ((r_state == S_ADDR) && rx_valid) begin
        r_base <= rx_data;
        r_sum  <= rx_data;
      end
      if ((r_state == S_LEN) && rx_valid) begin
        r_len <= rx_data;
        r_sum <= r_sum + rx_data;
      end
      if ((r_state == S_PAYLOAD) && rx_valid) begin
        r_sum <= r_sum + rx_data;
      end

      if (w_clrIdx) begin
        r_idx <= 8'd0;
      end else if (w_incIdx) begin
        r_idx <= r_idx + 8'd1;
      end

      if (!w_timerRun || rx_valid) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TW'(1);
      end
    end
  end

  // Payload buffer; contents are only meaningful once written, so no reset.
  always_ff @(posedge clk) begin
    if (w_bufWe) begin
      r_buf[w_bufIdx] <= rx_data;
    end
  end

  // Registered status: busy tracks the next state, flags pulse for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy       <= 1'b0;
      r_frameOk    <= 1'b0;
      r_errChk     <= 1'b0;
      r_errLen     <= 1'b0;
      r_errTimeout <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_busy       <= (w_nextState != S_IDLE);
      r_frameOk    <= w_setOk;
      r_errChk     <= w_setErrChk;
      r_errLen     <= w_setErrLen;
      r_errTimeout <= w_setErrTimeout;
      r_overrun    <= w_setOverrun;
    end
  end

  // The write bus is a decode of DRAIN, so it drops as soon as reset hits;
  // address and data are forced to zero whenever no write is offered.
  assign wr_valid    = (r_state == S_DRAIN);
  assign wr_addr     = wr_valid ? (r_base + r_idx) : 8'd0;
  assign wr_data     = wr_valid ? r_buf[w_bufIdx] : 8'd0;
  assign busy        = r_busy;
  assign frame_ok    = r_frameOk;
  assign err_chk     = r_errChk;
  assign err_len     = r_errLen;
  assign err_timeout = r_errTimeout;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder
// Table of known frames, hand-written sequences for stall, timeout, overrun
// and reset, then random frames checked against a frame-level model.
module tb_uart_frame_decoder;

  localparam int TO      = 40;
  localparam int MAXL    = 16;
  localparam int NVEC    = 8;
  localparam int NRANDOM = 40;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       busy;
  logic       frame_ok;
  logic       err_chk;
  logic       err_len;
  logic       err_timeout;
  logic       overrun;

  uart_frame_decoder #(
    .SYNC_BYTE (8'hA5),
    .MAX_LEN   (MAXL),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .busy        (busy),
    .frame_ok    (frame_ok),
    .err_chk     (err_chk),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .overrun     (overrun)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [0:11][7:0] bytes;
    int               nBytes;
    int               expOk;
    int               expChk;
    int               expLen;
    logic [0:3][15:0] expWr;
    int               nWr;
  } vec_t;

  vec_t vecs [NVEC];

  int checks;
  int failures;

  int cntOk;
  int cntChk;
  int cntLen;
  int cntTo;
  int cntOvr;
  int baseOk;
  int baseChk;
  int baseLen;
  int baseTo;
  int baseOvr;
  int baseObs;

  logic [15:0] obsQ [$];
  logic [15:0] expQ [$];
  logic [7:0]  payQ [$];

  logic       stallPrev;
  logic [7:0] stallAddr;
  logic [7:0] stallData;
  logic       randReady;

  int         rAddr;
  int         rLen;
  int         rSum;
  int         rJunk;
  logic [7:0] rByte;
  logic       rGood;

  // One comparison: counts it, and reports it when the values differ.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One clock: observe the bus at the negedge, then move just past the posedge.
  task automatic tick();
    @(negedge clk);
    if (stallPrev) begin
      checkOutput("stallHold", {15'd0, wr_valid, wr_addr, wr_data},
                  {15'd0, 1'b1, stallAddr, stallData});
    end
    if (wr_valid && wr_ready) begin
      obsQ.push_back({wr_addr, wr_data});
    end
    stallPrev = wr_valid && !wr_ready;
    stallAddr = wr_addr;
    stallData = wr_data;
    if (frame_ok)    cntOk++;
    if (err_chk)     cntChk++;
    if (err_len)     cntLen++;
    if (err_timeout) cntTo++;
    if (overrun)     cntOvr++;
    @(posedge clk);
    #1;
    if (randReady) begin
      wr_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Presents one received byte for a single cycle.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic idleGap(input int maxGap);
    int n;
    n = $urandom_range(0, maxGap);
    repeat (n) tick();
  endtask

  // Bounded wait for the decoder to return to idle, plus time for pulses.
  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy && (n < 400)) begin
      tick();
      n++;
    end
    checkOutput({name, ".idleWait"}, {31'd0, busy}, 32'd0);
    tick();
    tick();
  endtask

  task automatic takeSnapshot();
    baseOk  = cntOk;
    baseChk = cntChk;
    baseLen = cntLen;
    baseTo  = cntTo;
    baseOvr = cntOvr;
    baseObs = obsQ.size();
    expQ.delete();
  endtask

  // Compares pulses and writes seen since the last snapshot to expectations.
  task automatic checkFrame(input string name, input int eOk, input int eChk,
                            input int eLen, input int eTo, input int eOvr);
    int nObs;
    int nCmp;
    nObs = obsQ.size() - baseObs;
    checkOutput({name, ".frameOk"}, cntOk - baseOk, eOk);
    checkOutput({name, ".errChk"}, cntChk - baseChk, eChk);
    checkOutput({name, ".errLen"}, cntLen - baseLen, eLen);
    checkOutput({name, ".errTimeout"}, cntTo - baseTo, eTo);
    checkOutput({name, ".overrun"}, cntOvr - baseOvr, eOvr);
    checkOutput({name, ".nWrites"}, nObs, expQ.size());
    nCmp = (nObs < expQ.size()) ? nObs : expQ.size();
    for (int i = 0; i < nCmp; i++) begin
      checkOutput($sformatf("%s.wr%0d", name, i), {16'd0, obsQ[baseObs + i]},
                  {16'd0, expQ[i]});
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cntOk     = 0;
    cntChk    = 0;
    cntLen    = 0;
    cntTo     = 0;
    cntOvr    = 0;
    stallPrev = 1'b0;
    stallAddr = 8'd0;
    stallData = 8'd0;
    randReady = 1'b0;
    rst_n     = 1'b0;
    rx_data   = 8'd0;
    rx_valid  = 1'b0;
    wr_ready  = 1'b0;

    // Frame vectors: bytes (left aligned), count, ok/chk/len pulses, writes.
    vecs[0] = '{96'hA5_10_03_11_22_33_79_00_00_00_00_00, 7, 1, 0, 0,
                64'h1011_1122_1233_0000, 3};
    vecs[1] = '{96'hA5_10_03_11_22_33_78_00_00_00_00_00, 7, 0, 1, 0,
                64'h0, 0};
    vecs[2] = '{96'hA5_FF_02_AA_BB_66_00_00_00_00_00_00, 6, 1, 0, 0,
                64'hFFAA_00BB_0000_0000, 2};
    vecs[3] = '{96'hA5_00_11_00_00_00_00_00_00_00_00_00, 3, 0, 0, 1,
                64'h0, 0};
    vecs[4] = '{96'hA5_00_00_00_00_00_00_00_00_00_00_00, 4, 1, 0, 0,
                64'h0, 0};
    vecs[5] = '{96'h3C_5A_A5_20_01_7E_9F_00_00_00_00_00, 7, 1, 0, 0,
                64'h207E_0000_0000_0000, 1};
    vecs[6] = '{96'hA5_FE_03_01_02_03_07_00_00_00_00_00, 7, 1, 0, 0,
                64'hFE01_FF02_0003_0000, 3};
    vecs[7] = '{96'hA5_A5_01_A5_4B_00_00_00_00_00_00_00, 5, 1, 0, 0,
                64'hA5A5_0000_0000_0000, 1};

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.busy", {31'd0, busy}, 32'd0);
    checkOutput("rst.wrValid", {31'd0, wr_valid}, 32'd0);
    checkOutput("rst.wrAddr", {24'd0, wr_addr}, 32'd0);
    checkOutput("rst.wrData", {24'd0, wr_data}, 32'd0);
    checkOutput("rst.pulses",
                {27'd0, frame_ok, err_chk, err_len, err_timeout, overrun}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven frames with an always-ready sink.
    wr_ready = 1'b1;
    for (int v = 0; v < NVEC; v++) begin
      takeSnapshot();
      for (int i = 0; i < vecs[v].nBytes; i++) begin
        applyStimulus(vecs[v].bytes[i]);
      end
      waitIdle($sformatf("vec%0d", v));
      for (int i = 0; i < vecs[v].nWr; i++) begin
        expQ.push_back(vecs[v].expWr[i]);
      end
      checkFrame($sformatf("vec%0d", v), vecs[v].expOk, vecs[v].expChk,
                 vecs[v].expLen, 0, 0);
    end

    // Stalled sink: first write held stable, address wraps FF -> 00.
    takeSnapshot();
    wr_ready = 1'b0;
    applyStimulus(8'hA5);
    applyStimulus(8'hFF);
    applyStimulus(8'h02);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    applyStimulus(8'h66);
    checkOutput("stall.valid", {31'd0, wr_valid}, 32'd1);
    checkOutput("stall.first", {16'd0, wr_addr, wr_data}, 32'h0000FFAA);
    repeat (5) tick();
    checkOutput("stall.held", {15'd0, wr_valid, wr_addr, wr_data}, 32'h0001FFAA);
    wr_ready = 1'b1;
    tick();
    checkOutput("stall.second", {15'd0, wr_valid, wr_addr, wr_data}, 32'h000100BB);
    checkOutput("stall.noEarlyOk", {31'd0, frame_ok}, 32'd0);
    tick();
    checkOutput("stall.done", {29'd0, wr_valid, frame_ok, busy}, 32'b010);
    tick();
    checkOutput("stall.okPulse1", {31'd0, frame_ok}, 32'd0);
    expQ.push_back(16'hFFAA);
    expQ.push_back(16'h00BB);
    checkFrame("stall", 1, 0, 0, 0, 0);

    // Inter-byte timeout fires exactly TO cycles after the last byte.
    takeSnapshot();
    applyStimulus(8'hA5);
    applyStimulus(8'h10);
    repeat (TO - 1) tick();
    checkOutput("to.before", {30'd0, busy, err_timeout}, 32'b10);
    tick();
    checkOutput("to.fire", {30'd0, busy, err_timeout}, 32'b01);
    tick();
    checkOutput("to.pulse1", {31'd0, err_timeout}, 32'd0);
    applyStimulus(8'h3C);
    applyStimulus(8'h5A);
    tick();
    checkOutput("to.junkIgnored", {31'd0, busy}, 32'd0);
    checkFrame("to", 0, 0, 0, 1, 0);

    // A byte landing on the expiry cycle wins over the timeout.
    takeSnapshot();
    applyStimulus(8'hA5);
    applyStimulus(8'h10);
    repeat (TO - 1) tick();
    applyStimulus(8'h00);
    checkOutput("toEdge.len", {30'd0, busy, err_timeout}, 32'b10);
    repeat (TO - 1) tick();
    applyStimulus(8'h10);
    waitIdle("toEdge");
    checkFrame("toEdge", 1, 0, 0, 0, 0);

    // Overrun during DRAIN, then reset mid-DRAIN loses the pending write.
    takeSnapshot();
    wr_ready = 1'b0;
    applyStimulus(8'hA5);
    applyStimulus(8'h30);
    applyStimulus(8'h02);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h35);
    applyStimulus(8'hA5);
    checkOutput("ovr.pulse", {31'd0, overrun}, 32'd1);
    checkOutput("ovr.wrKept", {15'd0, wr_valid, wr_addr, wr_data}, 32'h00013001);
    tick();
    checkOutput("ovr.pulse1", {31'd0, overrun}, 32'd0);
    wr_ready = 1'b1;
    tick();
    wr_ready = 1'b0;
    checkOutput("ovr.next", {15'd0, wr_valid, wr_addr, wr_data}, 32'h00013102);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstDrain.abort", {30'd0, wr_valid, busy}, 32'd0);
    stallPrev = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    expQ.push_back(16'h3001);
    checkFrame("rstDrain", 0, 0, 0, 0, 1);

    // Random frames against a frame-level model.
    randReady = 1'b1;
    for (int f = 0; f < NRANDOM; f++) begin
      takeSnapshot();
      payQ.delete();
      rJunk = $urandom_range(0, 2);
      for (int j = 0; j < rJunk; j++) begin
        rByte = 8'($urandom_range(0, 255));
        if (rByte == 8'hA5) rByte = 8'h00;
        applyStimulus(rByte);
        idleGap(2);
      end
      rAddr = $urandom_range(0, 255);
      rLen  = ((f % 5) == 0) ? MAXL : $urandom_range(0, MAXL + 2);
      applyStimulus(8'hA5);
      idleGap(3);
      applyStimulus(8'(rAddr));
      idleGap(3);
      applyStimulus(8'(rLen));
      if (rLen > MAXL) begin
        waitIdle($sformatf("rnd%0d", f));
        checkFrame($sformatf("rnd%0d", f), 0, 0, 1, 0, 0);
      end else begin
        rSum = rAddr + rLen;
        for (int i = 0; i < rLen; i++) begin
          idleGap(3);
          rByte = 8'($urandom_range(0, 255));
          payQ.push_back(rByte);
          rSum = rSum + int'(rByte);
          applyStimulus(rByte);
        end
        rGood = ($urandom_range(0, 3) != 0);
        idleGap(3);
        if (rGood) begin
          applyStimulus(8'(rSum % 256));
        end else begin
          applyStimulus(8'((rSum + $urandom_range(1, 255)) % 256));
        end
        waitIdle($sformatf("rnd%0d", f));
        if (rGood) begin
          for (int i = 0; i < rLen; i++) begin
            expQ.push_back({8'((rAddr + i) % 256), payQ[i]});
          end
          checkFrame($sformatf("rnd%0d", f), 1, 0, 0, 0, 0);
        end else begin
          checkFrame($sformatf("rnd%0d", f), 0, 1, 0, 0, 0);
        end
      end
    end
    randReady = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
